cbus_regfile: RTL
=================

// Module: cbus_regfile
// PURPOSE
//  Register bank that consumes the ALU result (cbus_in, n, z) and drives the ALU operand buses.
//  abus_out/bbus_out are combinational reads; ALU writeback and pointer increments are clocked.
//  Also holds the N/Z condition flags used by the branch logic.
//  There is no cbus->abus bypass, because the ALU is combinational and a bypass would form a loop.
// PARAMETERS
//  WIDTH     32  data width of the buses and registers
//  NUM_REGS  16  number of registers; index 0 is hardwired to zero
//  SEL_W     4   width of every register select; must satisfy 2**SEL_W >= NUM_REGS
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  a_sel      in   SEL_W  register index driven onto abus_out
//  b_sel      in   SEL_W  register index driven onto bbus_out
//  abus_out   out  WIDTH  ALU operand A (combinational read)
//  bbus_out   out  WIDTH  ALU operand B (combinational read)
//  cbus_in    in   WIDTH  ALU result to be written back
//  n          in   1      ALU negative flag
//  z          in   1      ALU zero flag
//  wr_en      in   1      write cbus_in into register wr_sel
//  wr_sel     in   SEL_W  destination register index
//  flag_we    in   1      capture n and z into n_flag/z_flag
//  inc_en     in   1      increment register inc_sel (loop/address pointer)
//  inc_sel    in   SEL_W  register index to increment
//  n_flag     out  1      registered N flag
//  z_flag     out  1      registered Z flag
//  wr_count   out  16     count of committed cbus writes, wraps at 16'hFFFF
// BEHAVIOUR
//  Reset (async, active-high):
//   - all registers = 0; n_flag = 0; z_flag = 1; wr_count = 0.
//   - Reset asserted mid-operation overrides any same-cycle write, increment or flag capture.
//  Reads:
//   - abus_out = reg[a_sel] and bbus_out = reg[b_sel], purely combinational.
//   - Index 0, or any index >= NUM_REGS, reads 0.
//   - a_sel == b_sel is legal; both buses then carry the same value.
//  Writeback:
//   - On a rising edge with wr_en=1 and 0 < wr_sel < NUM_REGS: reg[wr_sel] <= cbus_in.
//   - The new value appears on the read buses 1 cycle after the edge (no bypass).
//   - If wr_sel is 0 or >= NUM_REGS: no register changes and wr_count does not increment.
//  Increment:
//   - On a rising edge with inc_en=1 and a valid inc_sel: reg[inc_sel] <= reg[inc_sel] + 1.
//   - Result is taken modulo 2**WIDTH, so FFFF_FFFF wraps to 0.
//   - If inc_sel is 0 or >= NUM_REGS, the increment is ignored.
//  Simultaneous events:
//   - wr_en and inc_en targeting the same register: the write wins and the increment is dropped.
//   - wr_en and inc_en targeting different registers: both take effect in the same cycle.
//  Flags:
//   - On an edge with flag_we=1: n_flag <= n and z_flag <= z.
//   - Otherwise the flags hold. Flags are independent of wr_en.
//  wr_count:
//   - +1 per committed write, modulo 2**16.
//  Single-cycle operation throughout: there is no stall or handshake.
//   - The controller must hold a_sel/b_sel stable for the ALU settle time before the edge.
// TESTING
//  - Reset pulse mid-run: read every index -> 0; n_flag=0, z_flag=1, wr_count=0, all asynchronously before the next edge.
//  - wr_en=1, wr_sel=3, cbus_in=32'h0000_00A5; next cycle a_sel=3 -> abus_out=32'hA5; wr_count=1.
//  - wr_en=1, wr_sel=0, cbus_in=32'hDEAD_BEEF -> a_sel=0 still reads 0 and wr_count is unchanged.
//  - reg5=32'hFFFF_FFFF, inc_en=1, inc_sel=5 -> reg5=0. Then in one cycle: inc_sel=5 with wr_sel=5, cbus_in=7 -> reg5=7.
//  - flag_we=1 with n=1, z=0 -> n_flag=1, z_flag=0. Then flag_we=0 with n=0, z=1 -> flags hold at 1/0.
//  - 65536 consecutive valid writes -> wr_count wraps to 0; a_sel=b_sel=3 -> abus_out==bbus_out.

Source files
------------

// File: rtl/cbus_regfile_if.sv
// Bus bundle between the datapath controller and the register bank.
// The master drives selects, the ALU result and the strobes; the slave returns the operands, flags and write count.
interface cbus_regfile_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] a_sel;
  logic [SEL_W-1:0] b_sel;
  logic [WIDTH-1:0] abus_out;
  logic [WIDTH-1:0] bbus_out;
  logic [WIDTH-1:0] cbus_in;
  logic             n;
  logic             z;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic             flag_we;
  logic             inc_en;
  logic [SEL_W-1:0] inc_sel;
  logic             n_flag;
  logic             z_flag;
  logic [15:0]      wr_count;

  modport master (
    output a_sel, b_sel, cbus_in, n, z, wr_en, wr_sel, flag_we, inc_en, inc_sel,
    input  abus_out, bbus_out, n_flag, z_flag, wr_count
  );

  modport slave (
    input  a_sel, b_sel, cbus_in, n, z, wr_en, wr_sel, flag_we, inc_en, inc_sel,
    output abus_out, bbus_out, n_flag, z_flag, wr_count
  );
endinterface

// File: rtl/cbus_regfile.sv
// Register bank feeding the ALU operand buses and absorbing the ALU result.
// Index 0 is hardwired to zero; the read buses are combinational with no cbus bypass.
module cbus_regfile #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input logic             clock,
  input logic             reset,
  cbus_regfile_if.slave   bus
);

  // Index 0 has no storage, so it can never be written and always reads zero.
  logic [WIDTH-1:0] regs [1:NUM_REGS-1];
  logic             n_flag_q;
  logic             z_flag_q;
  logic [15:0]      wr_count_q;
  logic             wr_valid;
  logic             inc_valid;

  assign wr_valid  = bus.wr_en  && (bus.wr_sel  != '0) && (int'(bus.wr_sel)  < NUM_REGS);
  assign inc_valid = bus.inc_en && (bus.inc_sel != '0) && (int'(bus.inc_sel) < NUM_REGS);

  // Selects that match no stored register (0 or out of range) fall through to zero.
  always_comb begin
    bus.abus_out = '0;
    bus.bbus_out = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.a_sel == SEL_W'(i)) bus.abus_out = regs[i];
      if (bus.b_sel == SEL_W'(i)) bus.bbus_out = regs[i];
    end
  end

  // A write to the same register as an increment wins; different targets both commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_valid && bus.wr_sel == SEL_W'(i)) begin
          regs[i] <= bus.cbus_in;
        end else if (inc_valid && bus.inc_sel == SEL_W'(i)) begin
          regs[i] <= regs[i] + WIDTH'(1);
        end
      end
    end
  end

  // Condition flags reset to "zero result, not negative" and are independent of writeback.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b1;
    end else if (bus.flag_we) begin
      n_flag_q <= bus.n;
      z_flag_q <= bus.z;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
    end else if (wr_valid) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign bus.n_flag   = n_flag_q;
  assign bus.z_flag   = z_flag_q;
  assign bus.wr_count = wr_count_q;

endmodule
